uart_loader: RTL and testbench

//  Boot loader on the byte side of the UART AXI-lite bridge (t_valid/r_valid/rx_done/tx_done interface).

---
 rtl/uart_loader.sv | 194 +++++++++++++++++++
 tb/tb_uart_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// Boot loader: receives a word count and payload bytes over the UART bridge, writes words to instruction memory, then acks.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_loader #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              u_ready,
  input  logic [7:0]        r_data,
  input  logic              rx_done,
  input  logic              tx_done,
  output logic              r_valid,
  output logic              t_valid,
  output logic [7:0]        t_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RX_REQ, RX_WAIT, WRITE, ACK_REQ, ACK_WAIT, FIN, CHK} state_t;
  localparam state_t POST_DATA = CHK;
`else
  typedef enum logic [2:0] {IDLE, RX_REQ, RX_WAIT, WRITE, ACK_REQ, ACK_WAIT, FIN} state_t;
  localparam state_t POST_DATA = ACK_REQ;
`endif

  typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_CHK} phase_t;

  state_t            state, state_d;
  phase_t            phase, phase_d;
  logic [1:0]        byte_cnt, byte_cnt_d;
  logic [31:0]       acc, acc_d;
  logic [31:0]       n_words, n_words_d;
  logic [31:0]       word_idx, word_idx_d;
  logic              r_valid_d, t_valid_d, mem_we_d, busy_d, done_d, err_d;
  logic [7:0]        t_data_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum, csum_d;
`endif

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state;
    phase_d     = phase;
    byte_cnt_d  = byte_cnt;
    acc_d       = acc;
    n_words_d   = n_words;
    word_idx_d  = word_idx;
    r_valid_d   = 1'b0;
    t_valid_d   = 1'b0;
    mem_we_d    = 1'b0;
    t_data_d    = t_data;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    busy_d      = busy;
    done_d      = done;
    err_d       = err;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum;
`endif
    case (state)
      IDLE: if (start) begin
        busy_d     = 1'b1;
        done_d     = 1'b0;
        err_d      = 1'b0;
        phase_d    = PH_HDR;
        byte_cnt_d = 2'd0;
        word_idx_d = 32'd0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = 8'h00;
`endif
        state_d    = RX_REQ;
      end
      RX_REQ: if (u_ready) begin
        r_valid_d = 1'b1;
        state_d   = RX_WAIT;
      end
      RX_WAIT: if (rx_done) begin
`ifdef LOADER_CHECKSUM_EN
        if (phase == PH_CHK) begin
          if (r_data != csum) err_d = 1'b1;
          state_d = ACK_REQ;
        end else
`endif
        begin
          acc_d[{byte_cnt, 3'b000} +: 8] = r_data;
          byte_cnt_d = byte_cnt + 2'd1;
          state_d    = RX_REQ;
`ifdef LOADER_CHECKSUM_EN
          if (phase == PH_DATA) csum_d = csum ^ r_data;
`endif
          if (byte_cnt == 2'd3) begin
            if (phase == PH_HDR) begin
              n_words_d = acc_d;
              if (acc_d == 32'd0) begin
                state_d = POST_DATA;
              end else if (acc_d > MAX_WORDS) begin
                err_d   = 1'b1;
                state_d = ACK_REQ;
              end else begin
                phase_d    = PH_DATA;
                word_idx_d = 32'd0;
              end
            end else begin
              // Strobe is registered here so it lands in the WRITE cycle
              mem_we_d    = 1'b1;
              mem_addr_d  = ADDR_W'(BASE_ADDR + word_idx);
              mem_wdata_d = acc_d;
              state_d     = WRITE;
            end
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx + 32'd1;
        state_d    = (word_idx + 32'd1 == n_words) ? POST_DATA : RX_REQ;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: if (u_ready) begin
        r_valid_d = 1'b1;
        phase_d   = PH_CHK;
        state_d   = RX_WAIT;
      end
`endif
      ACK_REQ: begin
        t_data_d = err ? 8'h55 : 8'hAA;
        if (u_ready) begin
          t_valid_d = 1'b1;
          state_d   = ACK_WAIT;
        end
      end
      ACK_WAIT: if (tx_done) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      phase     <= PH_HDR;
      byte_cnt  <= 2'd0;
      acc       <= 32'd0;
      n_words   <= 32'd0;
      word_idx  <= 32'd0;
      r_valid   <= 1'b0;
      t_valid   <= 1'b0;
      t_data    <= 8'h00;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      byte_cnt  <= byte_cnt_d;
      acc       <= acc_d;
      n_words   <= n_words_d;
      word_idx  <= word_idx_d;
      r_valid   <= r_valid_d;
      t_valid   <= t_valid_d;
      t_data    <= t_data_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: a host model queues bytes and expected writes/acks, a bridge model serves requests.
`timescale 1ns/1ps
module tb_uart_loader;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned BASE_ADDR = 5;
  localparam int unsigned MAX_WORDS = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0, rstn = 1'b0, start = 1'b0, u_ready = 1'b0;
  logic              rx_done = 1'b0, tx_done = 1'b0;
  logic [7:0]        r_data = 8'h00;
  logic              r_valid, t_valid, mem_we, busy, done, err;
  logic [7:0]        t_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  uart_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rstn(rstn), .start(start), .u_ready(u_ready), .r_data(r_data),
    .rx_done(rx_done), .tx_done(tx_done), .r_valid(r_valid), .t_valid(t_valid),
    .t_data(t_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0, n_pass = 0;
  int         cyc = 0, last_rx_cyc = 0, rx_cnt = 0;
  logic [7:0] host_q[$];
  logic [7:0] ack_q[$];
  logic [7:0] fixed_pl[$];
  wr_t        wr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Bridge model: serves one request at a time, randomly stalls u_ready, injects stray done pulses
  initial begin
    bit outst = 1'b0, outst_rx = 1'b0;
    int dly = 0, hold = 0;
    logic [7:0] t_hold = 8'h00;
    forever begin
      @(negedge clk);
      rx_done = 1'b0;
      tx_done = 1'b0;
      if (!rstn) begin
        outst = 1'b0;
      end else if (r_valid || t_valid) begin
        chk("req_rule", u_ready && !outst && !(r_valid && t_valid),
            32'({outst, u_ready, r_valid, t_valid}), 32'b0110);
        outst = 1'b1; outst_rx = r_valid; t_hold = t_data;
        dly = $urandom_range(1, 4);
      end else if (outst) begin
        dly--;
        if (dly == 0) begin
          outst = 1'b0;
          if (outst_rx) begin
            chk("rx_byte_expected", host_q.size() > 0, 32'(host_q.size()), 32'd1);
            r_data = (host_q.size() > 0) ? host_q.pop_front() : 8'($urandom);
            rx_cnt++;
            last_rx_cyc = cyc;
            rx_done = 1'b1;
          end else begin
            chk("t_data_stable", t_data == t_hold, 32'(t_data), 32'(t_hold));
            tx_done = 1'b1;
          end
        end
      end else if ($urandom_range(0, 15) == 0) begin
        r_data = 8'($urandom);
        if ($urandom_range(0, 1) == 1) rx_done = 1'b1;
        else tx_done = 1'b1;
      end
      if (hold > 0) begin
        hold--; u_ready = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        hold = 19; u_ready = 1'b0;
      end else begin
        u_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expected writes and acks as the DUT presents them
  initial begin
    wr_t w;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (rstn && mem_we) begin
        chk("write_expected", wr_q.size() > 0, 32'(mem_addr), 32'(wr_q.size()));
        chk("write_latency", cyc == last_rx_cyc + 1, 32'(cyc - last_rx_cyc), 32'd1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("write_addr", mem_addr == w.addr, 32'(mem_addr), 32'(w.addr));
          chk("write_data", mem_wdata == w.data, mem_wdata, w.data);
        end
      end
      if (rstn && t_valid) begin
        chk("ack_expected", ack_q.size() > 0, 32'(t_data), 32'(ack_q.size()));
        if (ack_q.size() > 0) begin
          a = ack_q.pop_front();
          chk("ack_byte", t_data == a, 32'(t_data), 32'(a));
        end
      end
    end
  end

  task automatic check_zero(input string name);
    chk({name, "_ctrl"}, {r_valid, t_valid, mem_we, busy, done, err} == 6'b0,
        32'({r_valid, t_valid, mem_we, busy, done, err}), 32'd0);
    chk({name, "_data"}, t_data == 8'h00 && mem_addr == '0 && mem_wdata == 32'd0,
        mem_wdata ^ 32'({t_data, mem_addr}), 32'd0);
  endtask

  // Host model: queue header/payload/checksum and the expected writes and ack, then run the load
  task automatic run_load(input logic [31:0] n, input bit bad_ck, input int abort_after);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    bit         e;
    wr_t        w;
    int         rx0, c;
    e = (n > MAX_WORDS);
    for (int i = 0; i < 4; i++) host_q.push_back(8'(n >> (8 * i)));
    if (!e) begin
      for (int wi = 0; wi < int'(n); wi++) begin
        w.data = 32'd0;
        for (int k = 0; k < 4; k++) begin
          b = (fixed_pl.size() > 0) ? fixed_pl.pop_front() : 8'($urandom);
          host_q.push_back(b);
          x = x ^ b;
          w.data[8 * k +: 8] = b;
        end
        w.addr = ADDR_W'((BASE_ADDR + wi) % (2 ** ADDR_W));
        wr_q.push_back(w);
      end
      if (CK_EN) begin
        host_q.push_back(bad_ck ? (x ^ 8'h01) : x);
        e = bad_ck;
      end
    end
    ack_q.push_back(e ? 8'h55 : 8'hAA);
    rx0 = rx_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_during_load", busy == 1'b1, 32'(busy), 32'd1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    if (abort_after > 0) begin
      c = 0;
      while (rx_cnt < rx0 + abort_after && c < 5000) begin @(negedge clk); c++; end
      chk("abort_reached", c < 5000, 32'(rx_cnt - rx0), 32'(abort_after));
      rstn = 1'b0;
      @(negedge clk);
      check_zero("abort_reset");
      chk("abort_partial_writes", wr_q.size() == int'(n) - 1, 32'(wr_q.size()), n - 32'd1);
      @(negedge clk);
      host_q.delete(); wr_q.delete(); ack_q.delete();
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      return;
    end
    c = 0;
    while (!done && c < 5000) begin @(negedge clk); c++; end
    chk("done", done == 1'b1, 32'(done), 32'd1);
    chk("err", err == e, 32'(err), 32'(e));
    chk("busy_clear", busy == 1'b0, 32'(busy), 32'd0);
    chk("bytes_consumed", host_q.size() == 0, 32'(host_q.size()), 32'd0);
    chk("writes_done", wr_q.size() == 0, 32'(wr_q.size()), 32'd0);
    chk("ack_done", ack_q.size() == 0, 32'(ack_q.size()), 32'd0);
    host_q.delete(); wr_q.delete(); ack_q.delete();
    repeat (3) @(negedge clk);
    chk("done_held", done == 1'b1 && err == e, 32'({done, err}), 32'({1'b1, e}));
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    fixed_pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(32'd2, 1'b0, 0);
    run_load(32'd0, 1'b0, 0);
    run_load(32'd17, 1'b0, 0);
    run_load(32'h0100_0000, 1'b1, 0);
    fixed_pl = {8'h01, 8'h02, 8'h04, 8'h08};
    run_load(32'd1, 1'b0, 0);
    fixed_pl = {8'h01, 8'h02, 8'h04, 8'h08};
    run_load(32'd1, 1'b1, 0);
    run_load(32'd16, 1'b0, 0);
    run_load(32'd3, 1'b0, 9);
    run_load(32'd1, 1'b0, 0);
    repeat (10) run_load(32'($urandom_range(0, 18)), 1'($urandom_range(0, 1)), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
